alu_share_ctrl: RTL

- Sequencer/arbiter that time-shares one combinational 32-bit ALU datapath (funct-coded, 6-bit opcode) between two requesters.
- Accepts operations over valid/ready, arbitrates round-robin, and drives registered operands and funct to the ALU.
- Waits a programmable settle time, captures the result, and returns it on a per-requester response channel.
- Sits between issue logic and the shared ALU; one operation in flight at a time.

---
 rtl/alu_share_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// One operation in flight; result returned on the owning requester's response channel.
module alu_share_ctrl #(
   parameter int DATA_W     = 32,
   parameter int FUNCT_W    = 6,
   parameter int ALU_SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [DATA_W-1:0]  req0_a,
   input  logic [DATA_W-1:0]  req0_b,
   input  logic [FUNCT_W-1:0] req0_funct,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [DATA_W-1:0]  req1_a,
   input  logic [DATA_W-1:0]  req1_b,
   input  logic [FUNCT_W-1:0] req1_funct,
   output logic               rsp0_valid,
   input  logic               rsp0_ready,
   output logic [DATA_W-1:0]  rsp0_data,
   output logic               rsp0_err,
   output logic               rsp1_valid,
   input  logic               rsp1_ready,
   output logic [DATA_W-1:0]  rsp1_data,
   output logic               rsp1_err,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [FUNCT_W-1:0] alu_funct,
   input  logic [DATA_W-1:0]  alu_result,
   output logic               busy
);

   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(ALU_SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_rr_ptr;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_id;

   logic               w_grant0;
   logic               w_grant1;
   logic               w_accept;
   logic [DATA_W-1:0]  w_sel_a;
   logic [DATA_W-1:0]  w_sel_b;
   logic [FUNCT_W-1:0] w_sel_funct;
   logic               w_legal;
   logic               w_rsp_hs;

   // Contention resolves to rr_ptr; a lone requester always wins.
   assign w_grant0 = req0_valid & (~req1_valid | ~r_rr_ptr);
   assign w_grant1 = req1_valid & (~req0_valid |  r_rr_ptr);

   assign req0_ready = (r_state == IDLE) & w_grant0;
   assign req1_ready = (r_state == IDLE) & w_grant1;
   assign w_accept   = req0_ready | req1_ready;

   assign w_sel_a     = w_grant1 ? req1_a     : req0_a;
   assign w_sel_b     = w_grant1 ? req1_b     : req0_b;
   assign w_sel_funct = w_grant1 ? req1_funct : req0_funct;

   always_comb begin
      w_legal = 1'b0;
      case (w_sel_funct[5:0])
         6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010: w_legal = 1'b1;
         default: w_legal = 1'b0;
      endcase
   end

   assign w_rsp_hs = (r_state == RESP) & (r_id ? rsp1_ready : rsp0_ready);
   assign busy     = (r_state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_rr_ptr   <= 1'b0;
         r_cnt      <= '0;
         r_id       <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_funct  <= '0;
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         rsp1_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_rr_ptr <= ~w_grant1;
                  r_id     <= w_grant1;
                  if (w_legal) begin
                     alu_a     <= w_sel_a;
                     alu_b     <= w_sel_b;
                     alu_funct <= w_sel_funct;
                     r_cnt     <= SETTLE_INIT;
                     r_state   <= SETTLE;
                  end else begin
                     // Illegal opcode: answer immediately, leave the ALU untouched.
                     if (w_grant1) begin
                        rsp1_valid <= 1'b1;
                        rsp1_data  <= '0;
                        rsp1_err   <= 1'b1;
                     end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_data  <= '0;
                        rsp0_err   <= 1'b1;
                     end
                     r_state <= RESP;
                  end
               end
            end
            SETTLE: begin
               if (r_cnt == '0) begin
                  if (r_id) begin
                     rsp1_valid <= 1'b1;
                     rsp1_data  <= alu_result;
                     rsp1_err   <= 1'b0;
                  end else begin
                     rsp0_valid <= 1'b1;
                     rsp0_data  <= alu_result;
                     rsp0_err   <= 1'b0;
                  end
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RESP: begin
               if (w_rsp_hs) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
